// File: rtl/ula_pkg.sv
// Shared encodings for the sequenced 4-bit ALU.
// Opcodes, FSM states and the reserved-opcode helper.
package ula_pkg;

    localparam logic [2:0] OP_SOMA   = 3'b000;
    localparam logic [2:0] OP_SUB    = 3'b001;
    localparam logic [2:0] OP_SOMA_C = 3'b010;
    localparam logic [2:0] OP_SUB_B  = 3'b011;
    localparam logic [2:0] OP_MUL    = 3'b100;

    localparam logic [1:0] OCIOSO     = 2'd0;
    localparam logic [1:0] EXECUTA    = 2'd1;
    localparam logic [1:0] MULTIPLICA = 2'd2;
    localparam logic [1:0] RESULTADO  = 2'd3;

    function automatic logic op_reservado(input logic [2:0] op);
        return op[2] && (op[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/ula_sequenciador_if.sv
// Command/result handshake bundle of the sequenced ALU.
// The ALU takes the slave side, its driver the master side.
interface ula_sequenciador_if;
    logic       entrada_valida;
    logic       entrada_pronta;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] resultado;
    logic       flag_zero;
    logic       flag_neg;
    logic       flag_carry;
    logic       flag_ov;
    logic       saida_valida;
    logic       saida_pronta;
    logic       op_invalida;

    modport slave (
        input  entrada_valida, op, a, b, saida_pronta,
        output entrada_pronta, resultado, flag_zero, flag_neg,
        output flag_carry, flag_ov, saida_valida, op_invalida
    );

    modport master (
        output entrada_valida, op, a, b, saida_pronta,
        input  entrada_pronta, resultado, flag_zero, flag_neg,
        input  flag_carry, flag_ov, saida_valida, op_invalida
    );
endinterface

// File: rtl/somador_subtrator_4bits.sv
// Combinational 4-bit adder/subtractor with carry-out and overflow.
// Subtraction is a + ~b + cin, so carry=1 means no borrow.
module somador_subtrator_4bits (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       modo_sub_i,
    input  logic       cin_i,
    output logic [4:0] s_o,
    output logic       ov_o
);
    logic [3:0] bmod;

    assign bmod = b_i ^ {4{modo_sub_i}};
    assign s_o  = {1'b0, a_i} + {1'b0, bmod} + {4'b0, cin_i};
    assign ov_o = (a_i[3] == bmod[3]) && (s_o[3] != a_i[3]);
endmodule

// File: rtl/ula_sequenciador.sv
// Sequenced 4-bit ALU: add/sub in one step, MUL by 4-step shift-add,
// both through a single shared adder; result held until consumed.
module ula_sequenciador
    import ula_pkg::*;
#(
    parameter int unsigned HABILITA_MUL = 1
) (
    input logic              clk,
    input logic              rst,
    ula_sequenciador_if.slave bus
);
    localparam bit MUL_ON = (HABILITA_MUL != 0);

    logic [1:0] estado_q, estado_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [3:0] hi_q, hi_d;
    logic [2:0] op_q, op_d;
    logic [1:0] cnt_q, cnt_d;
    logic       carry_q, carry_d;
    logic [7:0] res_q, res_d;
    logic       z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
    logic       inv_q, inv_d;

    logic [3:0] add_a, add_b;
    logic       modo_sub, cin;
    logic [4:0] s;
    logic       ov;
    logic [7:0] prod;

    somador_subtrator_4bits u_soma (
        .a_i       (add_a),
        .b_i       (add_b),
        .modo_sub_i(modo_sub),
        .cin_i     (cin),
        .s_o       (s),
        .ov_o      (ov)
    );

    // In MULTIPLICA a_q is the multiplicand and b_q the shifting low nibble
    always_comb begin
        add_a    = a_q;
        add_b    = b_q;
        modo_sub = 1'b0;
        cin      = 1'b0;
        if (estado_q == MULTIPLICA) begin
            add_a = hi_q;
            add_b = b_q[0] ? a_q : 4'h0;
        end else begin
            unique case (op_q)
                OP_SOMA:   cin = 1'b0;
                OP_SUB:    begin modo_sub = 1'b1; cin = 1'b1; end
                OP_SOMA_C: cin = carry_q;
                OP_SUB_B:  begin modo_sub = 1'b1; cin = carry_q; end
                default:   cin = 1'b0;
            endcase
        end
    end

    assign prod = {s, b_q[3:1]};

    always_comb begin
        estado_d = estado_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        res_d    = res_q;
        z_d      = z_q;
        n_d      = n_q;
        c_d      = c_q;
        v_d      = v_q;
        inv_d    = inv_q;
        case (estado_q)
            OCIOSO: begin
                if (bus.entrada_valida) begin
                    a_d   = bus.a;
                    b_d   = bus.b;
                    op_d  = bus.op;
                    hi_d  = 4'h0;
                    cnt_d = 2'd0;
                    if (MUL_ON && bus.op == OP_MUL) estado_d = MULTIPLICA;
                    else                            estado_d = EXECUTA;
                end
            end
            EXECUTA: begin
                res_d    = {4'h0, s[3:0]};
                c_d      = s[4];
                v_d      = ov;
                n_d      = s[3];
                z_d      = (s[3:0] == 4'h0);
                inv_d    = op_reservado(op_q);
                carry_d  = s[4];
                estado_d = RESULTADO;
            end
            MULTIPLICA: begin
                hi_d  = s[4:1];
                b_d   = {s[0], b_q[3:1]};
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    res_d    = prod;
                    c_d      = 1'b0;
                    v_d      = 1'b0;
                    n_d      = prod[7];
                    z_d      = (prod == 8'h00);
                    inv_d    = 1'b0;
                    carry_d  = 1'b0;
                    estado_d = RESULTADO;
                end
            end
            RESULTADO: begin
                if (bus.saida_pronta) estado_d = OCIOSO;
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= OCIOSO;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            res_q    <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            res_q    <= res_d;
            z_q      <= z_d;
            n_q      <= n_d;
            c_q      <= c_d;
            v_q      <= v_d;
            inv_q    <= inv_d;
        end
    end

    assign bus.entrada_pronta = (estado_q == OCIOSO);
    assign bus.saida_valida   = (estado_q == RESULTADO);
    assign bus.resultado      = res_q;
    assign bus.flag_zero      = z_q;
    assign bus.flag_neg       = n_q;
    assign bus.flag_carry     = c_q;
    assign bus.flag_ov        = v_q;
    assign bus.op_invalida    = inv_q;
endmodule

// File: tb/tb_ula_sequenciador.sv
// Scoreboard bench for ula_sequenciador: expected results are queued
// at command time from an arithmetic model and popped on saida_valida.
module tb_ula_sequenciador;

    localparam logic [2:0] T_SOMA   = 3'b000;
    localparam logic [2:0] T_SUB    = 3'b001;
    localparam logic [2:0] T_SOMA_C = 3'b010;
    localparam logic [2:0] T_SUB_B  = 3'b011;
    localparam logic [2:0] T_MUL    = 3'b100;

    typedef struct {
        logic [7:0] res;
        logic [4:0] fl;
        int         ciclo;
    } esp_t;

    logic clk = 1'b0;
    logic rst;
    int   ciclo = 0;
    int   n_total = 0;
    int   n_ok = 0;
    logic carry_m;
    esp_t fila[$];

    always #5 clk = ~clk;
    always @(posedge clk) ciclo <= ciclo + 1;

    ula_sequenciador_if bus ();

    ula_sequenciador #(.HABILITA_MUL(1)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic checar(input string tag, input logic [31:0] obs,
                          input logic [31:0] esp);
        n_total++;
        if (obs === esp) n_ok++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, esp);
    endtask

    // fl = {zero, neg, carry, ov, op_invalida}
    function automatic esp_t modelo(input logic [2:0] op,
                                    input logic [3:0] a, input logic [3:0] b,
                                    input logic c);
        esp_t e;
        int ua, ub, sa, sb, r, sr, bin;
        logic [7:0] m;
        logic cy;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        bin = c ? 0 : 1;
        e.ciclo = 0;
        if (op == T_MUL) begin
            m = 8'(ua * ub);
            e.res = m;
            e.fl = {m == 8'h00, m[7], 1'b0, 1'b0, 1'b0};
        end else begin
            case (op)
                T_SUB:    begin r = ua - ub; sr = sa - sb; cy = (r >= 0); end
                T_SUB_B:  begin
                    r = ua - ub - bin; sr = sa - sb - bin; cy = (r >= 0);
                end
                T_SOMA_C: begin
                    r = ua + ub + int'(c); sr = sa + sb + int'(c); cy = (r > 15);
                end
                default:  begin r = ua + ub; sr = sa + sb; cy = (r > 15); end
            endcase
            m = {4'h0, 4'(r)};
            e.res = m;
            e.fl = {m == 8'h00, m[3], cy, (sr < -8) || (sr > 7),
                    op[2] && (op[1:0] != 2'b00)};
        end
        return e;
    endfunction

    task automatic executa(input logic [2:0] op, input logic [3:0] a,
                           input logic [3:0] b, input int espera);
        esp_t e, g;
        int t;
        @(negedge clk);
        t = 0;
        while (!bus.entrada_pronta && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!bus.entrada_pronta) checar("pronta_timeout", 0, 1);
        bus.entrada_valida = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        e = modelo(op, a, b, carry_m);
        carry_m = (op == T_MUL) ? 1'b0 : e.fl[2];
        e.ciclo = ciclo + ((op == T_MUL) ? 5 : 2);
        fila.push_back(e);
        @(negedge clk);
        bus.entrada_valida = 1'b0;
        bus.op = 3'($urandom);
        bus.a = 4'($urandom);
        bus.b = 4'($urandom);
        t = 0;
        while (!bus.saida_valida && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!bus.saida_valida) begin
            checar("saida_timeout", 0, 1);
            fila.delete();
            return;
        end
        g = fila.pop_front();
        checar("latencia", ciclo, g.ciclo);
        checar("resultado", bus.resultado, g.res);
        checar("flags", {bus.flag_zero, bus.flag_neg, bus.flag_carry,
                         bus.flag_ov, bus.op_invalida}, g.fl);
        for (int i = 0; i < espera; i++) begin
            bus.entrada_valida = 1'b1;
            bus.op = T_SOMA;
            bus.a = 4'h1;
            bus.b = 4'h1;
            @(negedge clk);
            checar("stall_res", bus.resultado, g.res);
            checar("stall_flags", {bus.flag_zero, bus.flag_neg, bus.flag_carry,
                                   bus.flag_ov, bus.op_invalida}, g.fl);
            checar("stall_hs", {bus.saida_valida, bus.entrada_pronta}, 2'b10);
        end
        bus.entrada_valida = 1'b0;
        bus.saida_pronta = 1'b1;
        @(negedge clk);
        bus.saida_pronta = 1'b0;
        checar("pos_handshake", {bus.saida_valida, bus.entrada_pronta}, 2'b01);
    endtask

    initial begin
        logic [2:0] rop;
        rst = 1'b1;
        carry_m = 1'b0;
        bus.entrada_valida = 1'b0;
        bus.saida_pronta = 1'b0;
        bus.op = 3'b0;
        bus.a = 4'h0;
        bus.b = 4'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checar("reset_res", bus.resultado, 8'h00);
        checar("reset_flags", {bus.flag_zero, bus.flag_neg, bus.flag_carry,
                               bus.flag_ov, bus.op_invalida}, 5'b0);
        checar("reset_hs", {bus.saida_valida, bus.entrada_pronta}, 2'b01);

        executa(T_SOMA, 4'h7, 4'h1, 0);
        executa(T_SUB, 4'h3, 4'h5, 0);
        executa(T_SUB_B, 4'h0, 4'h0, 0);
        executa(T_SOMA, 4'hF, 4'h1, 0);
        executa(T_SOMA_C, 4'h0, 4'h0, 0);
        executa(T_SUB, 4'h5, 4'h3, 0);
        executa(T_MUL, 4'hF, 4'hF, 10);
        executa(T_MUL, 4'h0, 4'h9, 0);
        executa(T_SOMA, 4'hF, 4'h1, 0);
        executa(T_MUL, 4'h3, 4'h2, 0);
        executa(T_SOMA_C, 4'h0, 4'h0, 0);
        executa(3'b110, 4'h2, 4'h3, 0);
        executa(T_SUB, 4'h8, 4'h1, 2);
        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 7));
            executa(rop, 4'($urandom), 4'($urandom), int'($urandom_range(0, 2)));
        end

        // Abort a MUL in its third iteration; carry must come back cleared
        executa(T_SOMA, 4'hF, 4'h1, 0);
        @(negedge clk);
        bus.entrada_valida = 1'b1;
        bus.op = T_MUL;
        bus.a = 4'hF;
        bus.b = 4'hF;
        @(negedge clk);
        bus.entrada_valida = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checar("abort_pre", bus.saida_valida, 1'b0);
        rst = 1'b1;
        bus.saida_pronta = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.saida_pronta = 1'b0;
        carry_m = 1'b0;
        checar("abort_res", bus.resultado, 8'h00);
        checar("abort_flags", {bus.flag_zero, bus.flag_neg, bus.flag_carry,
                               bus.flag_ov, bus.op_invalida}, 5'b0);
        checar("abort_hs", {bus.saida_valida, bus.entrada_pronta}, 2'b01);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checar("abort_quieto", bus.saida_valida, 1'b0);
        end
        executa(T_SOMA_C, 4'h0, 4'h0, 0);
        executa(T_SUB_B, 4'h6, 4'h2, 0);

        $display("%0d/%0d checks passed", n_ok, n_total);
        $finish;
    end

endmodule

// File: doc/ula_sequenciador.md
ULA_SEQUENCIADOR -- requirements
Module: ula_sequenciador

Interface
REQ-001 SHALL have parameter HABILITA_MUL, default 1, enabling the MUL opcode; when 0, MUL executes as SOMA.
REQ-002 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port entrada_valida, input, 1, command present.
REQ-005 SHALL have port entrada_pronta, output, 1, block accepts a command this cycle.
REQ-006 SHALL have port op, input, 3, opcode: 000 SOMA, 001 SUB, 010 SOMA_C (add with carry flag), 011 SUB_B (subtract with borrow), 100 MUL; 101-111 reserved.
REQ-007 SHALL have ports a and b, input, 4 each, unsigned or two's-complement operands.
REQ-008 SHALL have port resultado, output, 8, registered result; add/sub results occupy [3:0], with [7:4] zero.
REQ-009 SHALL have ports flag_zero, flag_neg, flag_carry, flag_ov, output, 1 each, registered flags.
REQ-010 SHALL have port saida_valida, output, 1, resultado and flags are valid.
REQ-011 SHALL have port saida_pronta, input, 1, downstream consumes the result.
REQ-012 SHALL have port op_invalida, output, 1, registered; set with the result of a reserved opcode.

Function
REQ-013 SHALL implement FSM states OCIOSO, EXECUTA, MULTIPLICA and RESULTADO.
REQ-014 SHALL assert entrada_pronta only in OCIOSO; it accepts when entrada_valida=1 and captures a, b and op.
REQ-015 SHALL move on acceptance to EXECUTA for SOMA, SUB, SOMA_C, SUB_B and reserved opcodes, and to MULTIPLICA for MUL.
REQ-016 SHALL drive the adder in EXECUTA as follows: SOMA modo_sub=0, cin=0; SUB modo_sub=1, cin=1; SOMA_C modo_sub=0, cin=carry_reg; SUB_B modo_sub=1, cin=carry_reg.
REQ-017 SHALL treat a reserved opcode as SOMA and set op_invalida=1.
REQ-018 SHALL register the outputs at the end of EXECUTA and go to RESULTADO: resultado[3:0]=s[3:0], flag_carry=s[4], flag_ov=(a[3]==bmod[3])&&(s[3]!=a[3]), flag_neg=s[3], flag_zero=(s[3:0]==0). The term bmod is b XOR modo_sub.
REQ-019 SHALL apply the subtraction convention carry=1 for no borrow (for example, 5-3 gives carry=1 and 3-5 gives carry=0).
REQ-020 SHALL give add/sub a latency of exactly 2 cycles: accept at cycle N, saida_valida=1 at cycle N+2.
REQ-021 SHALL perform MUL in MULTIPLICA as unsigned shift-add over exactly 4 iterations using the adder (modo_sub=0, cin=0).
REQ-022 SHALL, in each MUL iteration, add the multiplicand to the high nibble when the multiplier LSB is 1, then shift {carry, high, low} right by 1.
REQ-023 SHALL take the MUL result at accept cycle N+5 with resultado=a*b (8 bits), flag_carry=0, flag_ov=0, flag_neg=resultado[7] and flag_zero=(resultado==0).
REQ-024 SHALL hold resultado, the flags and saida_valida stable in RESULTADO until saida_pronta=1, then return to OCIOSO.
REQ-025 SHALL make a new command acceptable no earlier than the cycle after the handshake; accept and result SHALL never overlap.
REQ-026 SHALL update carry_reg from flag_carry on each completed add/sub; MUL SHALL clear carry_reg.
REQ-027 SHALL keep carry_reg unchanged by a result stall.
REQ-028 SHALL ignore entrada_valida outside OCIOSO; a, b and op may change freely after acceptance.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, enter OCIOSO, zero resultado, all flags, op_invalida, saida_valida and carry_reg, and set entrada_pronta=1 on the next cycle.
REQ-030 SHALL abort an operation in progress (EXECUTA, MULTIPLICA or RESULTADO) when rst occurs, with no result delivered.
REQ-031 SHALL give rst priority over simultaneous entrada_valida or saida_pronta.

Structure
REQ-032 SHALL place the opcode encodings and FSM state encodings in shared package ula_pkg.
REQ-033 SHALL instantiate somador_subtrator_4bits as its single sub-module, shared by add/sub and MUL; no second adder.
REQ-034 SHALL keep the adder combinational; all registers SHALL live in ula_sequenciador.

Verification
REQ-035 SHALL be verified by: SOMA a=7, b=1 -> resultado=0x08, flag_ov=1, flag_neg=1, flag_carry=0, saida_valida at N+2.
REQ-036 SHALL be verified by: SUB a=3, b=5 -> resultado=0x0E, flag_carry=0, flag_neg=1; then SUB_B a=0, b=0 -> resultado=0x0F.
REQ-037 SHALL be verified by: SOMA a=0xF, b=0x1 -> resultado=0x00, flag_zero=1, flag_carry=1; then SOMA_C a=0, b=0 -> resultado=0x01.
REQ-038 SHALL be verified by: MUL a=0xF, b=0xF -> resultado=0xE1 at N+5, flag_neg=1; MUL a=0, b=9 -> flag_zero=1.
REQ-039 SHALL be verified by: saida_pronta held at 0 for 10 cycles -> outputs stable, entrada_pronta=0, a second entrada_valida ignored.
REQ-040 SHALL be verified by: rst asserted during MULTIPLICA, cycle N+3 -> saida_valida never rises, next cycle all outputs are 0 and entrada_pronta=1.
